// File: rtl/llpm_select_rr_arbiter.sv
// Round-robin merge of NumInputs LI channels onto one output, burst-held up to MaxBurst transfers.
// Zero latency: a/a_valid/grant/x_bp are combinational from inputs and arbitration state.
// Backpressure locks the grant so source and data are stable; LLPM_SELECT_RR_STATS_EN adds starve_max.
module llpm_select_rr_arbiter #(
    parameter int Width          = 8,
    parameter int NumInputs      = 4,
    parameter int CLog2NumInputs = 2,
    parameter int MaxBurst       = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [Width*NumInputs-1:0]    x,
    input  logic [NumInputs-1:0]          x_valid,
    output logic [NumInputs-1:0]          x_bp,
    output logic [Width-1:0]              a,
    output logic                          a_valid,
    input  logic                          a_bp,
`ifdef LLPM_SELECT_RR_STATS_EN
    output logic [15:0]                   starve_max,
`endif
    output logic [CLog2NumInputs-1:0]     grant
);

    logic [CLog2NumInputs-1:0] last;
    logic                      lock;
    logic [CLog2NumInputs-1:0] lgrant;
    logic [7:0]                burst;

    logic                      scan_vld;
    logic [CLog2NumInputs-1:0] scan_idx;
    logic [8:0]                burst_inc;

    // First valid channel after the most recently rotated-out one; idle keeps the previous grant.
    always_comb begin
        int idx;
        scan_vld = 1'b0;
        scan_idx = lgrant;
        idx      = 0;
        for (int k = 1; k <= NumInputs; k++) begin
            idx = (int'(last) + k) % NumInputs;
            if (!scan_vld && x_valid[idx]) begin
                scan_vld = 1'b1;
                scan_idx = CLog2NumInputs'(idx);
            end
        end
    end

    always_comb begin
        grant   = lock ? lgrant : scan_idx;
        a_valid = lock ? x_valid[lgrant] : scan_vld;
        a       = x[int'(grant)*Width +: Width];
        for (int j = 0; j < NumInputs; j++) begin
            x_bp[j] = a_bp | ~a_valid | (CLog2NumInputs'(j) != grant);
        end
    end

    assign burst_inc = {1'b0, burst} + 9'd1;

    always_ff @(posedge clk) begin
        if (resetn) begin
            last   <= CLog2NumInputs'(NumInputs - 1);
            lock   <= 1'b0;
            lgrant <= '0;
            burst  <= '0;
        end else if (a_valid && a_bp) begin
            lock   <= 1'b1;
            lgrant <= grant;
        end else if (a_valid) begin
            lgrant <= grant;
            if (burst_inc < 9'(MaxBurst)) begin
                lock  <= 1'b1;
                burst <= burst_inc[7:0];
            end else begin
                lock  <= 1'b0;
                burst <= '0;
                last  <= grant;
            end
        end else if (lock) begin
            // Locked producer retracted valid: give up the lock and rotate past it.
            lock  <= 1'b0;
            burst <= '0;
            last  <= lgrant;
        end else begin
            lock  <= 1'b0;
            burst <= '0;
        end
    end

`ifdef LLPM_SELECT_RR_STATS_EN
    logic [15:0] starve_cnt     [NumInputs];
    logic [15:0] starve_cnt_nxt [NumInputs];
    logic [15:0] starve_max_nxt;

    always_comb begin
        starve_max_nxt = starve_max;
        for (int i = 0; i < NumInputs; i++) begin
            if (x_valid[i] && x_bp[i]) begin
                starve_cnt_nxt[i] = (starve_cnt[i] == 16'hFFFF) ? 16'hFFFF : starve_cnt[i] + 16'd1;
            end else begin
                starve_cnt_nxt[i] = '0;
            end
            if (starve_cnt_nxt[i] > starve_max_nxt) begin
                starve_max_nxt = starve_cnt_nxt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            starve_max <= '0;
            for (int i = 0; i < NumInputs; i++) begin
                starve_cnt[i] <= '0;
            end
        end else begin
            starve_max <= starve_max_nxt;
            for (int i = 0; i < NumInputs; i++) begin
                starve_cnt[i] <= starve_cnt_nxt[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_llpm_select_rr_arbiter.sv
// Directed bench for llpm_select_rr_arbiter: one instance with MaxBurst=1, one with MaxBurst=4.
module tb_llpm_select_rr_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] x;
    logic [3:0]  x_valid;
    logic        a_bp;

    logic [3:0]  x_bp1, x_bp4;
    logic [7:0]  a1, a4;
    logic        a_valid1, a_valid4;
    logic [1:0]  grant1, grant4;
`ifdef LLPM_SELECT_RR_STATS_EN
    logic [15:0] starve_max1, starve_max4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    llpm_select_rr_arbiter #(.Width(8), .NumInputs(4), .CLog2NumInputs(2), .MaxBurst(1)) dut1 (
        .clk(clk), .resetn(resetn), .x(x), .x_valid(x_valid), .x_bp(x_bp1),
        .a(a1), .a_valid(a_valid1), .a_bp(a_bp),
`ifdef LLPM_SELECT_RR_STATS_EN
        .starve_max(starve_max1),
`endif
        .grant(grant1)
    );

    llpm_select_rr_arbiter #(.Width(8), .NumInputs(4), .CLog2NumInputs(2), .MaxBurst(4)) dut4 (
        .clk(clk), .resetn(resetn), .x(x), .x_valid(x_valid), .x_bp(x_bp4),
        .a(a4), .a_valid(a_valid4), .a_bp(a_bp),
`ifdef LLPM_SELECT_RR_STATS_EN
        .starve_max(starve_max4),
`endif
        .grant(grant4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn  = 1'b1;
        x_valid = 4'b0000;
        a_bp    = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
        #1;
    endtask

    initial begin
        logic [1:0] eg;
        x = {8'h13, 8'h12, 8'h11, 8'h10};
        do_reset();

        // Reset state, idle
        chk("rst_a_valid", 32'(a_valid4), 32'd0);
        chk("rst_x_bp", 32'(x_bp4), 32'hF);
        chk("rst_grant", 32'(grant4), 32'd0);
        chk("rst1_x_bp", 32'(x_bp1), 32'hF);

        // MaxBurst=1: pure round robin over four valid inputs
        x_valid = 4'b1111;
        #1;
        for (int c = 0; c < 5; c++) begin
            eg = 2'(c % 4);
            chk("rr_a", 32'(a1), 32'(8'h10 + 8'(eg)));
            chk("rr_grant", 32'(grant1), 32'(eg));
            chk("rr_a_valid", 32'(a_valid1), 32'd1);
            tick();
        end

        // MaxBurst=4: channels 1 and 3 alternate in bursts of four
        do_reset();
        x_valid = 4'b1010;
        #1;
        for (int c = 0; c < 16; c++) begin
            eg = ((c / 4) % 2 == 1) ? 2'd3 : 2'd1;
            chk("burst_grant", 32'(grant4), 32'(eg));
            chk("burst_a", 32'(a4), 32'(8'h10 + 8'(eg)));
            chk("burst_bp1", 32'(x_bp4[1]), 32'(eg == 2'd3));
            tick();
        end

        // Stall on channel 2; channel 0 arrives mid-stall but must not steal the grant
        do_reset();
        x_valid = 4'b0100;
        a_bp    = 1'b1;
        #1;
        for (int s = 0; s < 5; s++) begin
            if (s == 2) begin
                x_valid = 4'b0101;
                #1;
            end
            chk("stall_grant", 32'(grant4), 32'd2);
            chk("stall_a", 32'(a4), 32'h12);
            chk("stall_x_bp", 32'(x_bp4), 32'hF);
            tick();
        end
        a_bp = 1'b0;
        #1;
        chk("unstall_grant", 32'(grant4), 32'd2);
        chk("unstall_x_bp", 32'(x_bp4), 32'b1011);
        tick();
        x_valid = 4'b0001;
        tick();
        chk("after_stall_grant", 32'(grant4), 32'd0);
        chk("after_stall_a_valid", 32'(a_valid4), 32'd1);

        // Single active channel: back-to-back transfers across burst boundaries
        do_reset();
        x_valid = 4'b0001;
        #1;
        for (int c = 0; c < 10; c++) begin
            chk("solo_a_valid", 32'(a_valid4), 32'd1);
            chk("solo_grant", 32'(grant4), 32'd0);
            chk("solo_x_bp", 32'(x_bp4), 32'b1110);
            tick();
        end

        // Reset during a locked stall on channel 3, channel 1 also valid
        do_reset();
        x_valid = 4'b1000;
        a_bp    = 1'b1;
        tick();
        tick();
        x_valid = 4'b1010;
        #1;
        chk("lock3_grant", 32'(grant4), 32'd3);
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        #1;
        chk("rst_stall_grant_ch1", 32'(grant4), 32'd1);
        chk("rst_stall_bp3", 32'(x_bp4[3]), 32'd1);
        a_bp = 1'b0;
        #1;
        chk("rst_stall_xfer_ch1", 32'(x_bp4), 32'b1101);

        // Same, but with channel 0 valid at reset release
        do_reset();
        x_valid = 4'b1000;
        a_bp    = 1'b1;
        tick();
        tick();
        x_valid = 4'b1011;
        #1;
        chk("lock3b_grant", 32'(grant4), 32'd3);
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        #1;
        chk("rst_stall_grant_ch0", 32'(grant4), 32'd0);
        chk("rst_stall_a_ch0", 32'(a4), 32'h10);

`ifdef LLPM_SELECT_RR_STATS_EN
        do_reset();
        chk("stats_reset", 32'(starve_max4), 32'd0);
        x_valid = 4'b1111;
        for (int c = 0; c < 64; c++) begin
            tick();
        end
        chk("starve_max", 32'(starve_max4), 32'd12);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
